// File: rtl/dmem_access_ctrl.sv
// dmem_access_ctrl: MEM-stage load/store bus sequencer with stall, timeout abort and load extension.
// Define DMEM_MISALIGN_TRAP_EN to trap misaligned H/W accesses instead of issuing them.
module dmem_access_ctrl #(
    parameter int TIMEOUT_CYC = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        FlushM,
    input  logic        MemRead_exe,
    input  logic        MemWrite_exe,
    input  logic [2:0]  funct3_exe,
    input  logic [31:0] alu_result_exe,
    input  logic [31:0] data2_decode_exe,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    output logic        StallM,
    output logic [31:0] load_data,
    output logic        mem_done,
    output logic        mem_err,
    output logic        misalign
);
    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;
    state_t state, next;
    logic [7:0] cnt;
    logic [1:0] off, sz;
    logic zext, err, mis;
    logic access, timeout, bad_align;
    logic [3:0] be_n;
    logic [31:0] wdata_n, sh, ext;
    logic [1:0] off_n;

    assign access = (MemRead_exe | MemWrite_exe) & ~FlushM;
    assign timeout = cnt >= 8'(TIMEOUT_CYC - 1);

`ifdef DMEM_MISALIGN_TRAP_EN
    assign bad_align = (funct3_exe[1:0] == 2'b01 && alu_result_exe[0]) ||
                       (funct3_exe[1] && alu_result_exe[1:0] != 2'b00);
`else
    assign bad_align = 1'b0;
`endif

    assign be_n = funct3_exe[1:0] == 2'b00 ? 4'b0001 << alu_result_exe[1:0] :
                  funct3_exe[1:0] == 2'b01 ? 4'b0011 << {alu_result_exe[1], 1'b0} : 4'b1111;
    assign wdata_n = funct3_exe[1:0] == 2'b00 ? {4{data2_decode_exe[7:0]}} :
                     funct3_exe[1:0] == 2'b01 ? {2{data2_decode_exe[15:0]}} : data2_decode_exe;
    assign off_n = funct3_exe[1:0] == 2'b00 ? alu_result_exe[1:0] :
                   funct3_exe[1:0] == 2'b01 ? {alu_result_exe[1], 1'b0} : 2'b00;

    assign sh = bus_rdata >> {off, 3'b000};
    assign ext = sz == 2'b00 ? (zext ? {24'b0, sh[7:0]} : {{24{sh[7]}}, sh[7:0]}) :
                 sz == 2'b01 ? (zext ? {16'b0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]}) : bus_rdata;

    assign mem_err = state == DONE && err;
    assign misalign = state == DONE && mis;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= next;
    end

    always_comb begin
        next = state;
        bus_req = 1'b0;
        StallM = 1'b0;
        mem_done = 1'b0;
        case (state)
            IDLE: begin
                StallM = access;
                if (access) next = bad_align ? DONE : REQ;
            end
            REQ: begin
                bus_req = 1'b1;
                StallM = 1'b1;
                if (bus_ack || timeout) next = DONE;
            end
            DONE: begin
                mem_done = 1'b1;
                next = IDLE;
            end
            default: next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
            off <= '0;
            sz <= '0;
            zext <= 1'b0;
            err <= 1'b0;
            mis <= 1'b0;
            bus_we <= 1'b0;
            bus_addr <= '0;
            bus_be <= '0;
            bus_wdata <= '0;
            load_data <= '0;
        end else if (state == IDLE && access) begin
            cnt <= '0;
            err <= 1'b0;
            mis <= bad_align;
            if (bad_align) begin
                load_data <= '0;
            end else begin
                bus_we <= MemWrite_exe;
                bus_addr <= {alu_result_exe[31:2], 2'b00};
                bus_be <= be_n;
                bus_wdata <= wdata_n;
                off <= off_n;
                sz <= funct3_exe[1:0];
                zext <= funct3_exe[2];
            end
        end else if (state == REQ) begin
            if (bus_ack) begin
                load_data <= bus_we ? 32'b0 : ext;
            end else if (timeout) begin
                err <= 1'b1;
                load_data <= '0;
            end else begin
                cnt <= cnt == 8'hFF ? cnt : cnt + 8'd1;
            end
        end
    end
endmodule

// File: tb/tb_dmem_access_ctrl.sv
// tb_dmem_access_ctrl: scoreboard bench; bus requests and completions are checked by a monitor.
module tb_dmem_access_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        FlushM = 1'b0;
    logic        MemRead_exe = 1'b0;
    logic        MemWrite_exe = 1'b0;
    logic [2:0]  funct3_exe = '0;
    logic [31:0] alu_result_exe = '0;
    logic [31:0] data2_decode_exe = '0;
    logic        bus_ack = 1'b0;
    logic [31:0] bus_rdata = '0;
    logic        bus_req, bus_we, StallM, mem_done, mem_err, misalign;
    logic [31:0] bus_addr, bus_wdata, load_data;
    logic [3:0]  bus_be;

    typedef struct {logic [31:0] addr; logic [31:0] wdata; logic [3:0] be; logic we;} bus_t;
    typedef struct {logic [31:0] data; logic err; logic mis;} resp_t;
    bus_t  exp_bus[$];
    resp_t exp_resp[$];
    int total = 0;
    int bad = 0;
    logic req_seen = 1'b0;

    dmem_access_ctrl #(.TIMEOUT_CYC(15)) dut (
        .clk(clk), .rst(rst), .FlushM(FlushM), .MemRead_exe(MemRead_exe),
        .MemWrite_exe(MemWrite_exe), .funct3_exe(funct3_exe), .alu_result_exe(alu_result_exe),
        .data2_decode_exe(data2_decode_exe), .bus_ack(bus_ack), .bus_rdata(bus_rdata),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be),
        .bus_wdata(bus_wdata), .StallM(StallM), .load_data(load_data), .mem_done(mem_done),
        .mem_err(mem_err), .misalign(misalign)
    );

    always #5 clk = ~clk;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", name, act, exp);
        end
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            req_seen = 1'b0;
        end else begin
            if (bus_req && !req_seen) begin
                req_seen = 1'b1;
                if (exp_bus.size() == 0) begin
                    check("bus_unexpected", {31'b0, bus_req}, 32'd0);
                end else begin
                    bus_t b;
                    b = exp_bus.pop_front();
                    check("bus_addr", bus_addr, b.addr);
                    check("bus_be", {28'b0, bus_be}, {28'b0, b.be});
                    check("bus_we", {31'b0, bus_we}, {31'b0, b.we});
                    check("bus_wdata", bus_wdata, b.wdata);
                end
            end
            if (!bus_req) req_seen = 1'b0;
            if (mem_done) begin
                if (exp_resp.size() == 0) begin
                    check("done_unexpected", {31'b0, mem_done}, 32'd0);
                end else begin
                    resp_t r;
                    r = exp_resp.pop_front();
                    check("load_data", load_data, r.data);
                    check("mem_err", {31'b0, mem_err}, {31'b0, r.err});
                    check("misalign", {31'b0, misalign}, {31'b0, r.mis});
                end
            end else if (mem_err || misalign) begin
                check("flag_without_done", {30'b0, mem_err, misalign}, 32'd0);
            end
        end
    end

    task automatic run(input logic rd, input logic wr, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] d, input int ack_after, input logic [31:0] rdat,
                       input logic fl, output int stalls, output int reqs);
        logic done = 1'b0;
        stalls = 0;
        reqs = 0;
        MemRead_exe = rd;
        MemWrite_exe = wr;
        funct3_exe = f3;
        alu_result_exe = a;
        data2_decode_exe = d;
        for (int c = 0; c < 100 && !done; c++) begin
            #1;
            if (StallM) stalls++;
            if (bus_req) begin
                reqs++;
                FlushM = fl;
                if (reqs == ack_after) begin
                    bus_ack = 1'b1;
                    bus_rdata = rdat;
                end
            end
            if (mem_done) begin
                done = 1'b1;
                MemRead_exe = 1'b0;
                MemWrite_exe = 1'b0;
                FlushM = 1'b0;
            end
            @(posedge clk);
            #1 bus_ack = 1'b0;
            bus_rdata = 32'hDEAD_BEEF;
            @(negedge clk);
        end
        if (!done) check("access_hang", 32'd0, 32'd1);
    endtask

    initial begin
        int st, rq, dn;
        repeat (2) @(negedge clk);
        check("rst_bus_req", {31'b0, bus_req}, 32'd0);
        check("rst_stall", {31'b0, StallM}, 32'd0);
        check("rst_addr", bus_addr, 32'd0);
        check("rst_be", {28'b0, bus_be}, 32'd0);
        check("rst_load", load_data, 32'd0);
        check("rst_flags", {29'b0, mem_done, mem_err, misalign}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        exp_bus.push_back('{32'h100, 32'h4444_4444, 4'b1000, 1'b0});
        exp_resp.push_back('{32'hFFFF_FF80, 1'b0, 1'b0});
        run(1, 0, 3'b000, 32'h103, 32'h1122_3344, 1, 32'h80FF_FF7F, 0, st, rq);
        check("lb_stalls", st, 2);

        exp_bus.push_back('{32'h200, 32'hABCD_ABCD, 4'b1100, 1'b1});
        exp_resp.push_back('{32'h0, 1'b0, 1'b0});
        run(0, 1, 3'b001, 32'h202, 32'h0000_ABCD, 3, 32'h0, 0, st, rq);
        check("sh_stalls", st, 4);

        exp_bus.push_back('{32'h10, 32'h0, 4'b1111, 1'b0});
        exp_resp.push_back('{32'h0, 1'b1, 1'b0});
        run(1, 0, 3'b010, 32'h10, 32'h0, 0, 32'h0, 0, st, rq);
        check("to_req_cycles", rq, 15);
        check("to_stalls", st, 16);

        exp_bus.push_back('{32'h100, 32'h0, 4'b0010, 1'b0});
        exp_resp.push_back('{32'h0000_0080, 1'b0, 1'b0});
        run(1, 0, 3'b100, 32'h101, 32'h0, 1, 32'h1234_8056, 0, st, rq);

        exp_bus.push_back('{32'h0, 32'h0, 4'b1100, 1'b0});
        exp_resp.push_back('{32'hFFFF_8001, 1'b0, 1'b0});
        run(1, 0, 3'b001, 32'h2, 32'h0, 2, 32'h8001_7FFF, 0, st, rq);

        exp_bus.push_back('{32'h0, 32'h0, 4'b0011, 1'b0});
        exp_resp.push_back('{32'h0000_F00D, 1'b0, 1'b0});
        run(1, 0, 3'b101, 32'h0, 32'h0, 1, 32'h8001_F00D, 0, st, rq);

        exp_bus.push_back('{32'h0, 32'hA5A5_A5A5, 4'b0010, 1'b1});
        exp_resp.push_back('{32'h0, 1'b0, 1'b0});
        run(1, 1, 3'b000, 32'h1, 32'h1234_56A5, 1, 32'hFFFF_FFFF, 0, st, rq);

        exp_bus.push_back('{32'h30, 32'hCAFE_BABE, 4'b1111, 1'b1});
        exp_resp.push_back('{32'h0, 1'b0, 1'b0});
        run(0, 1, 3'b011, 32'h30, 32'hCAFE_BABE, 2, 32'h0, 1, st, rq);
        check("flush_in_req_stalls", st, 3);

`ifdef DMEM_MISALIGN_TRAP_EN
        exp_resp.push_back('{32'h0, 1'b0, 1'b1});
        run(1, 0, 3'b010, 32'h2, 32'h0, 1, 32'h0102_0304, 0, st, rq);
        check("mis_reqs", rq, 0);
        check("mis_stalls", st, 1);
`else
        exp_bus.push_back('{32'h0, 32'h0, 4'b1111, 1'b0});
        exp_resp.push_back('{32'h0102_0304, 1'b0, 1'b0});
        run(1, 0, 3'b010, 32'h2, 32'h0, 1, 32'h0102_0304, 0, st, rq);
        check("mis_off_stalls", st, 2);
`endif

        MemRead_exe = 1'b1;
        FlushM = 1'b1;
        #1 check("flush_idle_stall", {31'b0, StallM}, 32'd0);
        @(negedge clk);
        check("flush_idle_req", {31'b0, bus_req}, 32'd0);
        MemRead_exe = 1'b0;
        FlushM = 1'b0;
        bus_ack = 1'b1;
        @(negedge clk);
        bus_ack = 1'b0;
        check("ack_idle_done", {30'b0, mem_done, bus_req}, 32'd0);

        exp_bus.push_back('{32'h40, 32'h0, 4'b1111, 1'b0});
        MemRead_exe = 1'b1;
        funct3_exe = 3'b010;
        alu_result_exe = 32'h40;
        data2_decode_exe = 32'h0;
        repeat (2) @(negedge clk);
        #1 check("rst_mid_req_before", {31'b0, bus_req}, 32'd1);
        rst = 1'b1;
        MemRead_exe = 1'b0;
        @(negedge clk);
        check("rst_mid_req", {31'b0, bus_req}, 32'd0);
        check("rst_mid_be", {28'b0, bus_be}, 32'd0);
        check("rst_mid_load", load_data, 32'd0);
        rst = 1'b0;
        bus_ack = 1'b1;
        @(negedge clk);
        bus_ack = 1'b0;
        dn = 0;
        for (int i = 0; i < 5; i++) begin
            if (mem_done || bus_req) dn++;
            @(negedge clk);
        end
        check("rst_late_ack", dn, 0);
        check("bus_queue_empty", exp_bus.size(), 0);
        check("resp_queue_empty", exp_resp.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/dmem_access_ctrl.md
DMEM_ACCESS_CTRL -- requirements
Module: dmem_access_ctrl

Interface
REQ-001 The block SHALL have parameter TIMEOUT_CYC, default 15, max REQ-state cycles (1..255) before abort.
REQ-002 The block SHALL have these ports (name  direction  width  meaning):
- clk  in  1  sole clock, rising edge.
- rst  in  1  synchronous active-high reset.
- FlushM  in  1  squash pending start in IDLE.
- MemRead_exe  in  1  load in MEM stage.
- MemWrite_exe  in  1  store in MEM stage.
- funct3_exe  in  3  size [1:0] (00 B, 01 H, 10 W, 11 treated as W); [2]=1 zero-extend.
- alu_result_exe  in  32  byte address.
- data2_decode_exe  in  32  store data.
- bus_ack  in  1  memory completion, single-cycle pulse.
- bus_rdata  in  32  read word, valid with bus_ack.
- bus_req  out  1  request, held until ack or timeout.
- bus_we  out  1  write strobe.
- bus_addr  out  32  {addr[31:2],2'b00}.
- bus_be  out  4  byte enables.
- bus_wdata  out  32  lane-replicated store data.
- StallM  out  1  hold pipeline upstream of MEM.
- load_data  out  32  extended load result.
- mem_done  out  1  one-cycle completion pulse.
- mem_err  out  1  one-cycle timeout pulse.
- misalign  out  1  one-cycle misaligned-access pulse.

Function
REQ-003 FSM states SHALL be IDLE, REQ, DONE; access = (MemRead_exe|MemWrite_exe) & ~FlushM.
REQ-004 IDLE: access -> REQ, StallM=1 (combinational); else stay, StallM=0.
REQ-005 REQ: bus_req=1, StallM=1; bus_addr/we/be/wdata SHALL be registered on IDLE->REQ and held constant.
REQ-006 REQ: bus_ack -> DONE, capture extended load_data; timeout counter = TIMEOUT_CYC without ack -> DONE, load_data=0, mem_err=1 in DONE.
REQ-007 DONE: StallM=0, mem_done=1 for exactly one cycle, unconditional -> IDLE; min access latency 2 stall cycles.
REQ-008 MemRead_exe & MemWrite_exe together SHALL be treated as a store.
REQ-009 bus_be SHALL be 0001<<addr[1:0] (B), 0011<<{addr[1],0} (H), 1111 (W); bus_wdata = byte x4, half x2, or word.
REQ-010 Loads SHALL select the addressed lane, sign-extend if funct3[2]=0, zero-extend if 1; stores set load_data=0.
REQ-011 bus_ack outside REQ SHALL be ignored; FlushM in REQ/DONE SHALL be ignored (bus transaction completes).
REQ-012 The timeout counter SHALL be 8 bits, clear on REQ entry, saturate; no wrap.

Reset
REQ-013 rst SHALL force IDLE, counter 0, and all outputs 0 on the next edge, including mid-REQ (bus_req dropped, access discarded).

Configuration
REQ-014 Macro DMEM_MISALIGN_TRAP_EN defined: H with addr[0]=1 or W with addr[1:0]!=0 SHALL skip REQ (IDLE->DONE, one stall cycle, no bus_req, misalign=1 in DONE, load_data=0).
REQ-015 Macro undefined: misalign tied 0; H/W lanes use addr with low bits cleared and the bus access proceeds normally.

Verification
REQ-016 LB at 0x103, bus_rdata=0x80FF_FF7F -> bus_be=1000, load_data=0xFFFF_FF80, StallM high 2+ cycles, mem_done once.
REQ-017 SH at 0x202, data 0x0000_ABCD, ack after 3 cycles -> bus_be=1100, bus_wdata=0xABCD_ABCD, bus_we=1, StallM 4 cycles.
REQ-018 LW, no ack, TIMEOUT_CYC=15 -> bus_req drops after 15 REQ cycles, mem_err=1, load_data=0.
REQ-019 rst in 2nd REQ cycle, then late bus_ack -> IDLE, bus_req=0, no mem_done.
REQ-020 LW at 0x002: macro on -> misalign=1, no bus_req; macro off -> bus_addr=0x0, bus_be=1111.
